// File: rtl/bench_dispatch_multi.sv
// bench_dispatch_multi: routes 193-bit benchmark commands to one of
// NUM_CHANNELS engines, or to all of them when dest is all-ones. It tracks
// per-channel busy state and run time and collects execution-cycle results.
// The optional per-channel watchdog is built when BENCH_TIMEOUT_EN is defined.
module bench_dispatch_multi #(
  parameter int          NUM_CHANNELS   = 2,
  parameter int          DEST_WIDTH     = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
  input  logic                         net_clk,
  input  logic                         net_rst,
  input  logic                         s_axis_cmd_valid,
  output logic                         s_axis_cmd_ready,
  input  logic [192:0]                 s_axis_cmd_data,
  input  logic [DEST_WIDTH-1:0]        s_axis_cmd_dest,
  output logic [NUM_CHANNELS*193-1:0]  m_bench_cfg,
  output logic [NUM_CHANNELS-1:0]      m_bench_start,
  input  logic [NUM_CHANNELS-1:0]      s_bench_cycles_valid,
  input  logic [NUM_CHANNELS*64-1:0]   s_bench_cycles_data,
  output logic [NUM_CHANNELS*64-1:0]   result_cycles,
  output logic [63:0]                  result_last,
  output logic [NUM_CHANNELS-1:0]      busy,
  output logic [NUM_CHANNELS*32-1:0]   run_cycles,
  output logic [31:0]                  done_count,
  output logic                         err_dest,
  output logic [NUM_CHANNELS-1:0]      timeout
);

  localparam logic [DEST_WIDTH-1:0] BCAST_DEST = '1;

  logic [NUM_CHANNELS*193-1:0] r_cfg;
  logic [NUM_CHANNELS-1:0]     r_start;
  logic [NUM_CHANNELS-1:0]     r_busy;
  logic [NUM_CHANNELS*32-1:0]  r_run;
  logic [NUM_CHANNELS*64-1:0]  r_result;
  logic [63:0]                 r_result_last;
  logic [31:0]                 r_done_count;
  logic                        r_err_dest;

  logic                        w_is_bcast;
  logic                        w_in_range;
  logic [NUM_CHANNELS-1:0]     w_target;
  logic                        w_ready;
  logic                        w_accept;
  logic [NUM_CHANNELS-1:0]     w_start;
  logic [NUM_CHANNELS-1:0]     w_done;
  logic [NUM_CHANNELS-1:0]     w_tmo;
  logic [63:0]                 w_last;
  logic [31:0]                 w_pop;

  // Decode destination, derive ready from busy state, and qualify completions.
  always_comb begin
    w_is_bcast = (s_axis_cmd_dest == BCAST_DEST);
    w_in_range = (int'(s_axis_cmd_dest) < NUM_CHANNELS);
    w_target   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_target[i] = w_is_bcast | (int'(s_axis_cmd_dest) == i);
    end
    if (w_is_bcast) begin
      w_ready = ~|r_busy;
    end else if (w_in_range) begin
      w_ready = ~|(r_busy & w_target);
    end else begin
      // Out-of-range commands are swallowed so the stream never stalls on them.
      w_ready = 1'b1;
    end
    w_ready  = w_ready & ~net_rst;
    w_accept = s_axis_cmd_valid & w_ready;
    w_start  = w_accept ? w_target : '0;
    // Completions from idle channels (e.g. in flight across a reset) are ignored.
    w_done   = s_bench_cycles_valid & r_busy;
    w_tmo    = '0;
`ifdef BENCH_TIMEOUT_EN
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_tmo[i] = r_busy[i] & ~w_done[i] &
                 (r_run[i*32 +: 32] == (TIMEOUT_CYCLES - 32'd1));
    end
`endif
  end

  // Pick the lowest-index completing channel's result and count completions.
  always_comb begin
    w_last = r_result_last;
    w_pop  = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (w_done[i]) begin
        w_last = s_bench_cycles_data[i*64 +: 64];
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_pop = w_pop + {31'd0, w_done[i]};
    end
  end

  // Per-channel start/run/complete state plus the shared result registers.
  always_ff @(posedge net_clk) begin
    if (net_rst) begin
      r_cfg         <= '0;
      r_start       <= '0;
      r_busy        <= '0;
      r_run         <= '0;
      r_result      <= '0;
      r_result_last <= '0;
      r_done_count  <= '0;
      r_err_dest    <= 1'b0;
    end else begin
      r_start <= w_start;
      if (w_accept && !w_is_bcast && !w_in_range) begin
        r_err_dest <= 1'b1;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (w_start[i]) begin
          r_cfg[i*193 +: 193]  <= s_axis_cmd_data;
          r_busy[i]            <= 1'b1;
          r_run[i*32 +: 32]    <= '0;
          r_result[i*64 +: 64] <= '0;
        end else if (w_done[i]) begin
          r_result[i*64 +: 64] <= s_bench_cycles_data[i*64 +: 64];
          r_busy[i]            <= 1'b0;
        end else if (w_tmo[i]) begin
          r_result[i*64 +: 64] <= '1;
          r_busy[i]            <= 1'b0;
        end else if (r_busy[i] && (r_run[i*32 +: 32] != 32'hFFFF_FFFF)) begin
          r_run[i*32 +: 32] <= r_run[i*32 +: 32] + 32'd1;
        end
      end
      if (|w_done) begin
        r_result_last <= w_last;
      end
      r_done_count <= r_done_count + w_pop;
    end
  end

`ifdef BENCH_TIMEOUT_EN
  logic [NUM_CHANNELS-1:0] r_timeout;

  // Sticky watchdog flags, cleared only by reset.
  always_ff @(posedge net_clk) begin
    if (net_rst) begin
      r_timeout <= '0;
    end else begin
      r_timeout <= r_timeout | w_tmo;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = '0;
`endif

  assign s_axis_cmd_ready = w_ready;
  assign m_bench_cfg      = r_cfg;
  assign m_bench_start    = r_start;
  assign busy             = r_busy;
  assign run_cycles       = r_run;
  assign result_cycles    = r_result;
  assign result_last      = r_result_last;
  assign done_count       = r_done_count;
  assign err_dest         = r_err_dest;

endmodule

// File: tb/tb_bench_dispatch_multi.sv
// Directed testbench for bench_dispatch_multi (two channels, 3-bit dest,
// broadcast dest = 3'b111, watchdog limit 16 when BENCH_TIMEOUT_EN is defined).
module tb_bench_dispatch_multi;

  logic         net_clk = 1'b0;
  logic         net_rst;
  logic         valid;
  logic         ready;
  logic [192:0] data;
  logic [2:0]   dest;
  logic [385:0] cfg;
  logic [1:0]   start;
  logic [1:0]   cv;
  logic [127:0] cd;
  logic [127:0] res;
  logic [63:0]  last;
  logic [1:0]   bsy;
  logic [63:0]  run;
  logic [31:0]  done;
  logic         errd;
  logic [1:0]   tmo;

  logic [192:0] d1, d2, d3, d4, d5;

  int n_assert = 0;
  int n_fail   = 0;

  bench_dispatch_multi #(
    .NUM_CHANNELS  (2),
    .DEST_WIDTH    (3),
    .TIMEOUT_CYCLES(32'd16)
  ) dut (
    .net_clk             (net_clk),
    .net_rst             (net_rst),
    .s_axis_cmd_valid    (valid),
    .s_axis_cmd_ready    (ready),
    .s_axis_cmd_data     (data),
    .s_axis_cmd_dest     (dest),
    .m_bench_cfg         (cfg),
    .m_bench_start       (start),
    .s_bench_cycles_valid(cv),
    .s_bench_cycles_data (cd),
    .result_cycles       (res),
    .result_last         (last),
    .busy                (bsy),
    .run_cycles          (run),
    .done_count          (done),
    .err_dest            (errd),
    .timeout             (tmo)
  );

  always #5 net_clk = ~net_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge net_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    d1 = '0; d1[192] = 1'b1; d1[47:0] = 48'h1000; d1[127:96] = 32'd10;
    d2 = '0; d2[47:0] = 48'h2000; d2[159:128] = 32'd64;
    d3 = '0; d3[192] = 1'b1; d3[95:48] = 48'h4000; d3[191:160] = 32'd8;
    d4 = '0; d4[47:0] = 48'hABCD; d4[127:96] = 32'd3;
    d5 = '0; d5[47:0] = 48'h5555;

    // Reset state
    net_rst = 1'b1; valid = 1'b0; data = '0; dest = 3'd0; cv = 2'b00; cd = '0;
    tick(); tick();
    chk("rst_ready", 200'(ready), 200'(1'b0));
    chk("rst_busy", 200'(bsy), 200'(2'b00));
    chk("rst_start", 200'(start), 200'(2'b00));
    chk("rst_cfg", 200'(cfg[192:0] | cfg[385:193]), 200'(0));
    chk("rst_res", 200'(res[63:0] | res[127:64]), 200'(0));
    chk("rst_last", 200'(last), 200'(0));
    chk("rst_run", 200'(run), 200'(0));
    chk("rst_done", 200'(done), 200'(0));
    chk("rst_err", 200'(errd), 200'(1'b0));
    chk("rst_tmo", 200'(tmo), 200'(2'b00));
    net_rst = 1'b0; #1;
    chk("idle_ready", 200'(ready), 200'(1'b1));

    // Unicast to channel 1
    dest = 3'd1; data = d1; valid = 1'b1; #1;
    chk("uni_ready", 200'(ready), 200'(1'b1));
    tick();
    valid = 1'b0;
    chk("uni_start", 200'(start), 200'(2'b10));
    chk("uni_busy", 200'(bsy), 200'(2'b10));
    chk("uni_cfg1", 200'(cfg[385:193]), 200'(d1));
    chk("uni_cfg0", 200'(cfg[192:0]), 200'(0));
    chk("uni_run0", 200'(run[63:32]), 200'(0));
    tick();
    chk("uni_start_pulse", 200'(start), 200'(2'b00));
    chk("uni_run1", 200'(run[63:32]), 200'(1));
    cv = 2'b10; cd = {64'd500, 64'd0};
    tick();
    cv = 2'b00;
    chk("uni_res1", 200'(res[127:64]), 200'(500));
    chk("uni_last", 200'(last), 200'(500));
    chk("uni_done", 200'(done), 200'(1));
    chk("uni_busy_clr", 200'(bsy), 200'(2'b00));
    chk("uni_run_frozen", 200'(run[63:32]), 200'(1));
    tick();
    chk("uni_run_hold", 200'(run[63:32]), 200'(1));

    // Back-pressure on channel 0
    dest = 3'd0; data = d2; valid = 1'b1;
    tick();
    data = d3; #1;
    chk("bp_busy", 200'(bsy), 200'(2'b01));
    chk("bp_ready_low", 200'(ready), 200'(1'b0));
    tick(); tick(); tick();
    chk("bp_ready_still_low", 200'(ready), 200'(1'b0));
    chk("bp_no_start", 200'(start), 200'(2'b00));
    chk("bp_cfg_kept", 200'(cfg[192:0]), 200'(d2));
    chk("bp_run3", 200'(run[31:0]), 200'(3));
    cv = 2'b01; cd = {64'd0, 64'd77};
    tick();
    cv = 2'b00; #1;
    chk("bp_ready_rise", 200'(ready), 200'(1'b1));
    chk("bp_res0", 200'(res[63:0]), 200'(77));
    chk("bp_done", 200'(done), 200'(2));
    tick();
    valid = 1'b0;
    chk("bp_restart", 200'(start), 200'(2'b01));
    chk("bp_run_restart", 200'(run[31:0]), 200'(0));
    chk("bp_cfg_new", 200'(cfg[192:0]), 200'(d3));
    chk("bp_res_cleared", 200'(res[63:0]), 200'(0));
    cv = 2'b01; cd = {64'd0, 64'd9};
    tick();
    cv = 2'b00;
    chk("bp_done3", 200'(done), 200'(3));

    // Broadcast with both channels idle
    dest = 3'b111; data = d4; valid = 1'b1; #1;
    chk("bc_ready", 200'(ready), 200'(1'b1));
    tick();
    valid = 1'b0;
    chk("bc_start", 200'(start), 200'(2'b11));
    chk("bc_busy", 200'(bsy), 200'(2'b11));
    chk("bc_cfg", 200'({cfg[385:193] ^ d4, cfg[192:0] ^ d4}), 200'(0));
    #1;
    chk("bc_ready_busy", 200'(ready), 200'(1'b0));
    cv = 2'b11; cd = {64'd200, 64'd100};
    tick();
    cv = 2'b00;
    chk("bc_last", 200'(last), 200'(100));
    chk("bc_done", 200'(done), 200'(5));
    chk("bc_res", 200'(res), 200'({64'd200, 64'd100}));
    chk("bc_busy_clr", 200'(bsy), 200'(2'b00));

    // Broadcast ready with one channel busy
    dest = 3'd1; data = d5; valid = 1'b1;
    tick();
    valid = 1'b0; dest = 3'b111; #1;
    chk("bc_part_ready", 200'(ready), 200'(1'b0));
    dest = 3'd0; #1;
    chk("uni_free_ready", 200'(ready), 200'(1'b1));
    cv = 2'b10; cd = {64'd300, 64'd0};
    tick();
    cv = 2'b00;
    chk("ch1_last", 200'(last), 200'(300));
    chk("ch1_done", 200'(done), 200'(6));

    // Out-of-range dest, then a spurious completion on an idle channel
    dest = 3'd5; data = d1; valid = 1'b1; #1;
    chk("bad_ready", 200'(ready), 200'(1'b1));
    tick();
    dest = 3'd2;
    chk("bad_no_start", 200'(start), 200'(2'b00));
    chk("bad_err", 200'(errd), 200'(1'b1));
    chk("bad_busy", 200'(bsy), 200'(2'b00));
    tick();
    valid = 1'b0;
    chk("bad2_no_start", 200'(start), 200'(2'b00));
    tick();
    chk("bad_err_sticky", 200'(errd), 200'(1'b1));
    cv = 2'b01; cd = {64'd0, 64'd999};
    tick();
    cv = 2'b00;
    chk("spur_res", 200'(res), 200'({64'd300, 64'd100}));
    chk("spur_done", 200'(done), 200'(6));
    chk("spur_last", 200'(last), 200'(300));

    // Reset while channel 0 runs
    dest = 3'd0; data = d5; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    chk("mid_busy", 200'(bsy), 200'(2'b01));
    net_rst = 1'b1; #1;
    chk("mid_rst_ready", 200'(ready), 200'(1'b0));
    tick();
    net_rst = 1'b0;
    chk("mid_busy0", 200'(bsy), 200'(2'b00));
    chk("mid_cfg0", 200'(cfg), 200'(0));
    chk("mid_misc0", 200'({res, last, run, done, errd, start, tmo}), 200'(0));
    cv = 2'b01; cd = {64'd0, 64'd1234};
    tick();
    cv = 2'b00;
    chk("mid_ignored", 200'({res, last, done}), 200'(0));

    // Completion in the watchdog's final cycle wins (channel 1)
    dest = 3'd1; data = d2; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("cw_run15", 200'(run[63:32]), 200'(15));
    cv = 2'b10; cd = {64'd42, 64'd0};
    tick();
    cv = 2'b00;
    chk("cw_res", 200'(res[127:64]), 200'(42));
    chk("cw_busy", 200'(bsy), 200'(2'b00));
    chk("cw_tmo", 200'(tmo), 200'(2'b00));
    chk("cw_done", 200'(done), 200'(1));

    // Channel 0 started with no completion
    dest = 3'd0; data = d3; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("to_busy15", 200'(bsy), 200'(2'b01));
    chk("to_tmo15", 200'(tmo), 200'(2'b00));
    tick();
`ifdef BENCH_TIMEOUT_EN
    chk("to_busy_clr", 200'(bsy), 200'(2'b00));
    chk("to_flag", 200'(tmo), 200'(2'b01));
    chk("to_res", 200'(res[63:0]), 200'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("to_done", 200'(done), 200'(1));
    tick(); tick();
    chk("to_sticky", 200'(tmo), 200'(2'b01));
`else
    chk("nto_busy", 200'(bsy), 200'(2'b01));
    chk("nto_tmo", 200'(tmo), 200'(2'b00));
    chk("nto_run", 200'(run[31:0]), 200'(16));
    cv = 2'b01; cd = {64'd0, 64'd55};
    tick();
    cv = 2'b00;
    chk("nto_res", 200'(res[63:0]), 200'(55));
    chk("nto_done", 200'(done), 200'(2));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
